// File: rtl/pe2_addsub_pipe.sv
// Multi-lane modular add/sub stage for the shared Kyber/Dilithium NTT datapath.
// Two-stage valid/ready pipeline: S1 = modular add/sub, S2 = optional halving.
module pe2_addsub_pipe #(
  parameter int LANES           = 4,
  parameter int DW              = 24,
  parameter int KQ              = 3329,
  parameter int DQ              = 8380417,
  parameter int BEATS_PER_FRAME = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mode,
  input  logic [1:0]            in_op,
  input  logic [LANES*DW-1:0]   in_a,
  input  logic [LANES*DW-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_sum,
  output logic [LANES*DW-1:0]   out_dif,
  output logic                  out_mode,
  output logic                  out_last,
  output logic                  err_op,
  output logic                  err_range,
  input  logic                  clr_err
);

  localparam int HW        = DW / 2;
  localparam int CW        = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
  localparam int LAST_I    = BEATS_PER_FRAME - 1;
  localparam int KQ_HALF_I = (KQ + 1) / 2;
  localparam int DQ_HALF_I = (DQ + 1) / 2;

  localparam logic [HW:0]   KQ_X    = KQ[HW:0];
  localparam logic [HW-1:0] KQ_W    = KQ[HW-1:0];
  localparam logic [HW-1:0] KQ_HALF = KQ_HALF_I[HW-1:0];
  localparam logic [DW:0]   DQ_X    = DQ[DW:0];
  localparam logic [DW-1:0] DQ_W    = DQ[DW-1:0];
  localparam logic [DW-1:0] DQ_HALF = DQ_HALF_I[DW-1:0];
  localparam logic [CW-1:0] LAST_CNT = LAST_I[CW-1:0];

  function automatic logic [HW-1:0] k_add(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= KQ_X) t = t - KQ_X;
    return t[HW-1:0];
  endfunction

  function automatic logic [HW-1:0] k_sub(input logic [HW-1:0] a, input logic [HW-1:0] b);
    logic [HW:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (a < b) t = t + KQ_X;
    return t[HW-1:0];
  endfunction

  // Odd x: (x+q)>>1 == (x>>1) + (q+1)/2 for odd q, so no extra carry bit is needed.
  function automatic logic [HW-1:0] k_half(input logic [HW-1:0] x);
    return {1'b0, x[HW-1:1]} + (x[0] ? KQ_HALF : '0);
  endfunction

  function automatic logic [DW-1:0] d_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] t;
    t = {1'b0, a} + {1'b0, b};
    if (t >= DQ_X) t = t - DQ_X;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] d_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] t;
    t = {1'b0, a} - {1'b0, b};
    if (a < b) t = t + DQ_X;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] d_half(input logic [DW-1:0] x);
    return {1'b0, x[DW-1:1]} + (x[0] ? DQ_HALF : '0);
  endfunction

  function automatic logic [DW-1:0] w_add(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic md);
    return md ? d_add(a, b) : {k_add(a[DW-1:HW], b[DW-1:HW]), k_add(a[HW-1:0], b[HW-1:0])};
  endfunction

  function automatic logic [DW-1:0] w_sub(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic md);
    return md ? d_sub(a, b) : {k_sub(a[DW-1:HW], b[DW-1:HW]), k_sub(a[HW-1:0], b[HW-1:0])};
  endfunction

  function automatic logic [DW-1:0] w_half(input logic [DW-1:0] x, input logic md);
    return md ? d_half(x) : {k_half(x[DW-1:HW]), k_half(x[HW-1:0])};
  endfunction

  function automatic logic w_oor(input logic [DW-1:0] x, input logic md);
    return md ? (x >= DQ_W) : ((x[DW-1:HW] >= KQ_W) || (x[HW-1:0] >= KQ_W));
  endfunction

  logic                s1_valid;
  logic                s1_mode;
  logic [1:0]          s1_op;
  logic [LANES*DW-1:0] s1_sum;
  logic [LANES*DW-1:0] s1_dif;
  logic [CW-1:0]       beat_cnt;

  logic                s1_ready;
  logic                s2_ready;
  logic                in_fire;
  logic                out_fire;
  logic                rng_nxt;
  logic [LANES*DW-1:0] sum_nxt;
  logic [LANES*DW-1:0] dif_nxt;
  logic [LANES*DW-1:0] sum2_nxt;
  logic [LANES*DW-1:0] dif2_nxt;

  assign s2_ready = ~out_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_last = out_valid & (beat_cnt == LAST_CNT);

  always_comb begin
    sum_nxt  = '0;
    dif_nxt  = '0;
    sum2_nxt = '0;
    dif2_nxt = '0;
    rng_nxt  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      sum_nxt[i*DW +: DW] = w_add(in_a[i*DW +: DW], in_b[i*DW +: DW], in_mode);
      dif_nxt[i*DW +: DW] = w_sub(in_a[i*DW +: DW], in_b[i*DW +: DW], in_mode);
      rng_nxt = rng_nxt | w_oor(in_a[i*DW +: DW], in_mode) | w_oor(in_b[i*DW +: DW], in_mode);
      case (s1_op)
        2'b01: begin
          sum2_nxt[i*DW +: DW] = w_half(s1_sum[i*DW +: DW], s1_mode);
          dif2_nxt[i*DW +: DW] = w_half(s1_dif[i*DW +: DW], s1_mode);
        end
        2'b10: begin
          sum2_nxt[i*DW +: DW] = w_half(s1_sum[i*DW +: DW], s1_mode);
          dif2_nxt[i*DW +: DW] = s1_dif[i*DW +: DW];
        end
        default: begin
          sum2_nxt[i*DW +: DW] = s1_sum[i*DW +: DW];
          dif2_nxt[i*DW +: DW] = s1_dif[i*DW +: DW];
        end
      endcase
    end
  end

  // Reserved op 11 is folded to 00 at S1 so S2 only ever sees a valid op.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s1_op    <= 2'b00;
      s1_sum   <= '0;
      s1_dif   <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= in_mode;
        s1_op   <= (in_op == 2'b11) ? 2'b00 : in_op;
        s1_sum  <= sum_nxt;
        s1_dif  <= dif_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_mode  <= 1'b0;
      out_sum   <= '0;
      out_dif   <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_mode <= s1_mode;
        out_sum  <= sum2_nxt;
        out_dif  <= dif2_nxt;
      end
    end
  end

  // A new error in the same cycle as clr_err wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_op    <= 1'b0;
      err_range <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      err_op    <= (in_fire & (in_op == 2'b11)) | (err_op & ~clr_err);
      err_range <= (in_fire & rng_nxt) | (err_range & ~clr_err);
      if (out_fire) beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pe2_addsub_pipe.sv
// Scoreboard bench for pe2_addsub_pipe: expected beats are queued at input
// handshake and compared in order at output handshake.
module tb_pe2_addsub_pipe;
  localparam int LANES = 4;
  localparam int DW    = 24;
  localparam int KQ    = 3329;
  localparam int DQ    = 8380417;
  localparam int BPF   = 32;
  localparam int W     = LANES * DW;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_mode = 1'b0;
  logic [1:0]   in_op = 2'b00;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic [W-1:0] out_dif;
  logic         out_mode;
  logic         out_last;
  logic         err_op;
  logic         err_range;
  logic         clr_err = 1'b0;

  typedef struct {
    logic [W-1:0] sum;
    logic [W-1:0] dif;
    logic         mode;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  int   n_out    = 0;
  int   n_last   = 0;
  bit   rand_rdy = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_sum = '0;
  logic [W-1:0] prev_dif = '0;
  logic         prev_mode = 1'b0;
  logic         prev_last = 1'b0;

  pe2_addsub_pipe #(
    .LANES(LANES), .DW(DW), .KQ(KQ), .DQ(DQ), .BEATS_PER_FRAME(BPF)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_op(in_op),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_dif(out_dif),
    .out_mode(out_mode), .out_last(out_last),
    .err_op(err_op), .err_range(err_range), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   exp_last;
    if (rst) begin
      exp_last = (exp_cnt == BPF - 1);
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_sum !== prev_sum || out_dif !== prev_dif ||
            out_mode !== prev_mode || out_last !== prev_last) begin
          n_fail++;
          $display("FAIL stall_hold: got valid=%0b sum=%h dif=%h mode=%0b last=%0b, want valid=1 sum=%h dif=%h mode=%0b last=%0b",
                   out_valid, out_sum, out_dif, out_mode, out_last, prev_sum, prev_dif, prev_mode, prev_last);
        end
      end
      if (out_valid !== 1'b1) begin
        n_checks++;
        if (out_last !== 1'b0) begin
          n_fail++;
          $display("FAIL last_idle: got out_last=%0b, want 0 while out_valid=0", out_last);
        end
      end else if (out_ready !== 1'b1) begin
        n_checks++;
        if (out_last !== exp_last) begin
          n_fail++;
          $display("FAIL last_stalled: got out_last=%0b, want %0b", out_last, exp_last);
        end
      end else begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got sum=%h dif=%h, want no output beat", out_sum, out_dif);
        end else begin
          e = sb.pop_front();
          if (out_sum !== e.sum || out_dif !== e.dif || out_mode !== e.mode || out_last !== exp_last) begin
            n_fail++;
            $display("FAIL beat_%0d: got sum=%h dif=%h mode=%0b last=%0b, want sum=%h dif=%h mode=%0b last=%0b",
                     n_out, out_sum, out_dif, out_mode, out_last, e.sum, e.dif, e.mode, exp_last);
          end
        end
        exp_cnt = (exp_cnt + 1) % BPF;
        n_out++;
        if (out_last === 1'b1) n_last++;
      end
      prev_stall = out_valid & ~out_ready;
      prev_sum   = out_sum;
      prev_dif   = out_dif;
      prev_mode  = out_mode;
      prev_last  = out_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic longint half_of(input longint x, input longint q);
    return (x % 2 == 0) ? x / 2 : (x + q) / 2;
  endfunction

  function automatic void model(input logic md, input logic [1:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] sum,
                                output logic [W-1:0] dif);
    longint q, mask, ea, eb, s, d;
    int ne, ew, off;
    sum  = '0;
    dif  = '0;
    ne   = md ? 1 : 2;
    ew   = md ? 24 : 12;
    q    = md ? longint'(DQ) : longint'(KQ);
    mask = (longint'(1) << ew) - 1;
    for (int l = 0; l < LANES; l++) begin
      for (int h = 0; h < ne; h++) begin
        off = l * DW + h * ew;
        ea = longint'(a >> off) & mask;
        eb = longint'(b >> off) & mask;
        s = ea + eb;
        if (s >= q) s = s - q;
        s = s & mask;
        d = ea - eb;
        if (d < 0) d = d + q;
        d = d & mask;
        if (op == 2'b01 || op == 2'b10) s = half_of(s, q);
        if (op == 2'b01) d = half_of(d, q);
        sum = sum | (W'(s) << off);
        dif = dif | (W'(d) << off);
      end
    end
  endfunction

  function automatic logic [W-1:0] rep(input logic [DW-1:0] w);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = w;
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word(input logic md);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*DW +: DW] = md ? DW'($urandom_range(0, DQ - 1))
                         : {12'($urandom_range(0, KQ - 1)), 12'($urandom_range(0, KQ - 1))};
    return r;
  endfunction

  task automatic send_beat(input logic md, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] es,
                           input logic [W-1:0] ed, input logic clr);
    exp_t e;
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_mode = md; in_op = op; in_a = a; in_b = b; clr_err = clr;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
    end
    if (ok) begin
      e.sum = es; e.dif = ed; e.mode = md;
      sb.push_back(e);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: in_ready=%0b for 200 cycles, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr_err = 1'b0;
  endtask

  task automatic send_model(input logic md, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic clr);
    logic [W-1:0] es, ed;
    model(md, op, a, b, es, ed);
    send_beat(md, op, a, b, es, ed, clr);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && c < 1000) begin
      @(posedge clk); #1;
      c++;
    end
    if (c >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d beats outstanding, want 0", sb.size());
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_mode !== 1'b0 ||
        out_sum !== '0 || out_dif !== '0 || err_op !== 1'b0 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%0b last=%0b mode=%0b sum=%h dif=%h eop=%0b erng=%0b, want all 0",
               out_valid, out_last, out_mode, out_sum, out_dif, err_op, err_range);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got in_ready=%0b, want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    int n0, l0;
    logic md;
    n0 = n_out; l0 = n_last;
    rand_rdy = 1'b1;
    for (int i = 0; i < 64; i++) begin
      md = 1'($urandom_range(0, 1));
      send_model(md, 2'($urandom_range(0, 2)), rand_word(md), rand_word(md), 1'b0);
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (n_out - n0 != 64 || n_last - l0 != 2) begin
      n_fail++;
      $display("FAIL stream_count: got beats=%0d lasts=%0d, want beats=64 lasts=2", n_out - n0, n_last - l0);
    end
  endtask

  task automatic test_directed();
    send_beat(1'b0, 2'b00, rep({12'd3328, 12'd3328}), rep({12'd1, 12'd0}),
              rep({12'd0, 12'd3328}), rep({12'd3327, 12'd3328}), 1'b0);
    send_beat(1'b0, 2'b01, rep(24'h001001), rep(24'h0), rep(24'h681681), rep(24'h681681), 1'b0);
    send_beat(1'b1, 2'b10, rep(24'd8380416), rep(24'd8380416), rep(24'd8380416), rep(24'd0), 1'b0);
    send_beat(1'b1, 2'b01, rep(24'd0), rep(24'd1), rep(24'd4190209), rep(24'd4190208), 1'b0);
    wait_drain();
    n_checks++;
    if (err_op !== 1'b0 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL directed_flags: got eop=%0b erng=%0b, want 0 0", err_op, err_range);
    end
  endtask

  task automatic test_errors();
    logic [W-1:0] a;
    send_model(1'b0, 2'b11, rep({12'd3000, 12'd17}), rep({12'd500, 12'd100}), 1'b0);
    n_checks++;
    if (err_op !== 1'b1 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL err_op_set: got eop=%0b erng=%0b, want 1 0", err_op, err_range);
    end
    a = rand_word(1'b1);
    a[2*DW +: DW] = 24'd8380417;
    send_model(1'b1, 2'b00, a, rep(24'd5), 1'b0);
    n_checks++;
    if (err_op !== 1'b1 || err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL err_range_set: got eop=%0b erng=%0b, want 1 1", err_op, err_range);
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    n_checks++;
    if (err_op !== 1'b0 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got eop=%0b erng=%0b, want 0 0", err_op, err_range);
    end
    send_model(1'b0, 2'b11, rand_word(1'b0), rand_word(1'b0), 1'b1);
    n_checks++;
    if (err_op !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_wins_op: got eop=%0b, want 1", err_op);
    end
    send_model(1'b1, 2'b00, rep(24'd8380417), rep(24'd3), 1'b1);
    n_checks++;
    if (err_op !== 1'b0 || err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL err_set_wins_range: got eop=%0b erng=%0b, want 0 1", err_op, err_range);
    end
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    a = rand_word(1'b0);
    a[DW +: 12] = 12'd3329;
    send_model(1'b0, 2'b00, a, rand_word(1'b0), 1'b0);
    n_checks++;
    if (err_op !== 1'b0 || err_range !== 1'b1) begin
      n_fail++;
      $display("FAIL err_range_k: got eop=%0b erng=%0b, want 0 1", err_op, err_range);
    end
    wait_drain();
  endtask

  task automatic test_reset_inflight();
    int n0, l0;
    logic md;
    out_ready = 1'b0;
    send_model(1'b1, 2'b11, rand_word(1'b1), rand_word(1'b1), 1'b0);
    send_model(1'b0, 2'b01, rand_word(1'b0), rand_word(1'b0), 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_mode !== 1'b1 || err_op !== 1'b1) begin
      n_fail++;
      $display("FAIL inflight_setup: got valid=%0b mode=%0b eop=%0b, want 1 1 1", out_valid, out_mode, err_op);
    end
    #2 rst = 1'b0;
    sb.delete();
    exp_cnt = 0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || out_mode !== 1'b0 || out_sum !== '0 ||
        out_dif !== '0 || err_op !== 1'b0 || err_range !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_reset: got valid=%0b last=%0b mode=%0b sum=%h eop=%0b erng=%0b, want all 0",
               out_valid, out_last, out_mode, out_sum, err_op, err_range);
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL inflight_release: got in_ready=%0b out_valid=%0b, want 1 0", in_ready, out_valid);
    end
    n0 = n_out; l0 = n_last;
    for (int i = 0; i < BPF; i++) begin
      md = 1'($urandom_range(0, 1));
      send_model(md, 2'($urandom_range(0, 2)), rand_word(md), rand_word(md), 1'b0);
    end
    wait_drain();
    n_checks++;
    if (n_out - n0 != BPF || n_last - l0 != 1) begin
      n_fail++;
      $display("FAIL frame_after_reset: got beats=%0d lasts=%0d, want beats=%0d lasts=1",
               n_out - n0, n_last - l0, BPF);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_directed();
    test_errors();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want completion", $time);
    $fatal(1);
  end

endmodule
